// File: rtl/start_rle_streamer.sv
// Start-screen RLE streamer: expands run-length words from a synchronous ROM into
// one palette index per visible VGA pixel, with 2x horizontal and 2x vertical upscale.
module start_rle_streamer #(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned RUN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_tick,
  input  logic              frame_start,
  input  logic              active,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [3:0]        start_color_index,
  output logic              index_valid,
  output logic              underrun
);
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = $clog2(IMG_H + 1);
  localparam logic [3:0]  DONE_COLOR = 4'd2;

  typedef enum logic [2:0] {
    IDLE, FETCH_CUR, LOAD_CUR, FETCH_NXT, LOAD_NXT, STREAM
  } state_t;

  typedef struct packed {
    logic [3:0]       col;
    logic [RUN_W-1:0] cnt;
  } run_t;

  // Everything needed to restart decoding at a source-line boundary
  typedef struct packed {
    run_t              cur;
    run_t              nxt;
    logic              nxt_valid;
    logic [ADDR_W-1:0] addr;
  } line_t;

  state_t            state, state_d;
  line_t             live, live_d, snap, snap_d;
  logic [COL_W-1:0]  col, col_d;
  logic [ROW_W-1:0]  row, row_d;
  logic              x_sub, x_sub_d, y_sub, y_sub_d;
  logic              primed, primed_d, done, done_d, snap_pend, snap_pend_d;
  logic [3:0]        index_d;
  logic              index_valid_d, underrun_d;
  run_t              rom_run;

  logic show, consume, wrap, replay, last, advance, swap;

  assign rom_run  = {rom_data[15:12], RUN_W'(rom_data[11:0])};
  assign rom_addr = live.addr;

  // Tick qualification: only once the run registers have been primed for this frame
  assign show    = primed && pix_tick && active && !frame_start;
  assign consume = show && !done && x_sub;
  assign wrap    = consume && (col == COL_W'(IMG_W - 1));
  assign replay  = wrap && !y_sub;
  assign last    = wrap && y_sub && (row == ROW_W'(IMG_H - 1));
  assign advance = consume && !replay && !last;
  assign swap    = advance && (live.cur.cnt == '0) && live.nxt_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = IDLE;
      FETCH_CUR: state_d = LOAD_CUR;
      LOAD_CUR:  state_d = FETCH_NXT;
      FETCH_NXT: state_d = LOAD_NXT;
      LOAD_NXT:  state_d = STREAM;
      STREAM:    if (swap) state_d = FETCH_NXT;
      default:   state_d = IDLE;
    endcase
    // replay discards an in-flight prefetch; the final pixel ends all ROM traffic
    if (replay || last) state_d = STREAM;
    if (frame_start)    state_d = FETCH_CUR;
  end

  // Datapath and output next values
  always_comb begin
    live_d        = live;
    snap_d        = snap;
    col_d         = col;
    row_d         = row;
    x_sub_d       = x_sub;
    y_sub_d       = y_sub;
    primed_d      = primed;
    done_d        = done;
    snap_pend_d   = snap_pend;
    index_d       = start_color_index;
    index_valid_d = 1'b0;
    underrun_d    = underrun;

    if (frame_start) begin
      live_d.addr      = '0;
      live_d.nxt_valid = 1'b0;
      col_d            = '0;
      row_d            = '0;
      x_sub_d          = 1'b0;
      y_sub_d          = 1'b0;
      primed_d         = 1'b0;
      done_d           = 1'b0;
      snap_pend_d      = 1'b0;
    end else begin
      if (state == LOAD_CUR) begin
        live_d.cur  = rom_run;
        live_d.addr = live.addr + ADDR_W'(1);
      end
      if (state == LOAD_NXT) begin
        live_d.nxt       = rom_run;
        live_d.nxt_valid = 1'b1;
        live_d.addr      = live.addr + ADDR_W'(1);
      end

      if (show) begin
        index_valid_d = 1'b1;
        index_d       = done ? DONE_COLOR : live.cur.col;
        x_sub_d       = !x_sub;
      end
      if (consume) col_d = wrap ? '0 : col + COL_W'(1);

      if (advance) begin
        if (live.cur.cnt != '0) begin
          live_d.cur.cnt = live.cur.cnt - RUN_W'(1);
        end else if (live.nxt_valid) begin
          live_d.cur       = live.nxt;
          live_d.nxt_valid = 1'b0;
        end else begin
          underrun_d = 1'b1;
        end
      end

      if (replay) begin
        live_d  = snap;
        y_sub_d = 1'b1;
      end
      if (wrap && y_sub) begin
        y_sub_d = 1'b0;
        row_d   = row + ROW_W'(1);
        done_d  = last;
      end

      // Line snapshots: at first entry to STREAM, and at each new source line once nxt is valid
      if (state == LOAD_NXT && !primed) begin
        primed_d = 1'b1;
        snap_d   = live_d;
      end
      if (wrap && y_sub && !last) begin
        if (live_d.nxt_valid) snap_d = live_d;
        else                  snap_pend_d = 1'b1;
      end
      if (state == LOAD_NXT && snap_pend && !replay) begin
        snap_d      = live_d;
        snap_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live              <= '0;
      snap              <= '0;
      col               <= '0;
      row               <= '0;
      x_sub             <= 1'b0;
      y_sub             <= 1'b0;
      primed            <= 1'b0;
      done              <= 1'b0;
      snap_pend         <= 1'b0;
      start_color_index <= '0;
      index_valid       <= 1'b0;
      underrun          <= 1'b0;
    end else begin
      live              <= live_d;
      snap              <= snap_d;
      col               <= col_d;
      row               <= row_d;
      x_sub             <= x_sub_d;
      y_sub             <= y_sub_d;
      primed            <= primed_d;
      done              <= done_d;
      snap_pend         <= snap_pend_d;
      start_color_index <= index_d;
      index_valid       <= index_valid_d;
      underrun          <= underrun_d;
    end
  end

endmodule
